// File: rtl/sram_access_m.sv
// rtl/sram_access_m.sv - registered request/ack initiator for an asynchronous 64Kx8 SRAM
module sram_access_m #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req,
  input  logic        req_rnw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [15:0] addr,
  inout  wire  [7:0]  data,
  output logic        ceb,
  output logic        rnw,
  output logic        oeb
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        is_read, is_read_n;
  logic [15:0] addr_n;
  logic [7:0]  wdata, wdata_n;
  logic [7:0]  rdata_n;
  logic        data_oe, data_oe_n;
  logic        ceb_n, rnw_n, oeb_n, busy_n, ack_n;
  logic        wr_phase;

  // Bus is driven only from registered write data under a registered enable.
  assign data = data_oe ? wdata : 8'hzz;

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, request capture, and the next value of every pin flop derived from the next state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    is_read_n = is_read;
    addr_n    = addr;
    wdata_n   = wdata;
    rdata_n   = rdata;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_n   = ST_SETUP;
          is_read_n = req_rnw;
          addr_n    = req_addr;
          wdata_n   = req_wdata;
        end
      end
      ST_SETUP: begin
        state_n = ST_ACCESS;
        cnt_n   = CNT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          state_n = ST_HOLD;
          if (is_read) begin
            rdata_n = data;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_HOLD: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Write data and rnw=0 span SETUP..HOLD so rnw only moves while ceb is high.
    wr_phase  = !is_read_n && ((state_n == ST_SETUP) || (state_n == ST_ACCESS) ||
                               (state_n == ST_HOLD));
    ceb_n     = (state_n != ST_ACCESS);
    oeb_n     = !(is_read_n && (state_n == ST_ACCESS));
    rnw_n     = !wr_phase;
    data_oe_n = wr_phase;
    busy_n    = (state_n != ST_IDLE);
    ack_n     = (state_n == ST_DONE);
  end

  // Pin, status and captured-request flops; reset forces the SRAM side inactive at once.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt     <= 4'd0;
      is_read <= 1'b1;
      addr    <= 16'h0000;
      wdata   <= 8'h00;
      rdata   <= 8'h00;
      data_oe <= 1'b0;
      ceb     <= 1'b1;
      rnw     <= 1'b1;
      oeb     <= 1'b1;
      busy    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      is_read <= is_read_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      rdata   <= rdata_n;
      data_oe <= data_oe_n;
      ceb     <= ceb_n;
      rnw     <= rnw_n;
      oeb     <= oeb_n;
      busy    <= busy_n;
      ack     <= ack_n;
    end
  end

endmodule

// File: tb/tb_sram_access_m.sv
// tb/tb_sram_access_m.sv - table-driven and randomized bench for sram_access_m
`timescale 1ns/1ps
module tb_sram_access_m;

  localparam int ACC0 = 2;
  localparam int ACC1 = 1;

  logic clk = 1'b0;
  logic resetb = 1'b1;
  always #5 clk = ~clk;

  logic        req0, req_rnw0, busy0, ack0, ceb0, rnw0, oeb0;
  logic [15:0] req_addr0, addr0;
  logic [7:0]  req_wdata0, rdata0;
  wire  [7:0]  data0;

  logic        req1, req_rnw1, busy1, ack1, ceb1, rnw1, oeb1;
  logic [15:0] req_addr1, addr1;
  logic [7:0]  req_wdata1, rdata1;
  wire  [7:0]  data1;

  logic [7:0] sram0 [65536];
  logic [7:0] sram1 [65536];
  logic [7:0] ref_mem [2][65536];

  int   checks = 0;
  int   errors = 0;
  int   ackc [2];
  bit   chk_en;
  logic prev_ceb [2];
  logic prev_rnw [2];
  logic prev_ack [2];

  typedef struct {
    int          u;
    logic        r;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
    int          exp_lat;
  } vec_t;

  assign data0 = (!ceb0 && !oeb0 && rnw0) ? sram0[addr0] : 8'hzz;
  assign data1 = (!ceb1 && !oeb1 && rnw1) ? sram1[addr1] : 8'hzz;

  sram_access_m #(.ACC_CYCLES(ACC0)) dut0 (
    .clk(clk), .resetb(resetb), .req(req0), .req_rnw(req_rnw0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .busy(busy0), .ack(ack0), .rdata(rdata0), .addr(addr0),
    .data(data0), .ceb(ceb0), .rnw(rnw0), .oeb(oeb0)
  );

  sram_access_m #(.ACC_CYCLES(ACC1)) dut1 (
    .clk(clk), .resetb(resetb), .req(req1), .req_rnw(req_rnw1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .busy(busy1), .ack(ack1), .rdata(rdata1), .addr(addr1),
    .data(data1), .ceb(ceb1), .rnw(rnw1), .oeb(oeb1)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic f_busy(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  function automatic logic f_ack(input int u);
    return (u == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [7:0] f_rdata(input int u);
    return (u == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("FAIL %s: got %0h, must differ from %0h at %0t", nm, act, bad, $time);
    end
  endtask

  task automatic drive_req(input int u, input logic v, input logic r, input logic [15:0] a,
                           input logic [7:0] wd);
    if (u == 0) begin
      req0 = v; req_rnw0 = r; req_addr0 = a; req_wdata0 = wd;
    end else begin
      req1 = v; req_rnw1 = r; req_addr1 = a; req_wdata1 = wd;
    end
  endtask

  task automatic do_access(input int u, input logic r, input logic [15:0] a, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd);
    drive_req(u, 1'b1, r, a, wd);
    @(posedge clk); #1;
    drive_req(u, 1'b0, r, a, wd);
    check($sformatf("u%0d_busy_after_accept", u), f_busy(u), 1'b1);
    lat = 0;
    rd  = 8'h00;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (f_ack(u)) begin
        lat = n;
        rd  = f_rdata(u);
        break;
      end
    end
    check($sformatf("u%0d_ack_seen", u), (lat != 0), 1'b1);
    @(posedge clk); #1;
    check($sformatf("u%0d_busy_after_done", u), f_busy(u), 1'b0);
    check($sformatf("u%0d_ack_one_cycle", u), f_ack(u), 1'b0);
  endtask

  task automatic proto_check(input int u, input logic cb, input logic ob, input logic rw,
                             input logic ak, input logic [7:0] bus, input logic [7:0] sm);
    if (chk_en) begin
      check($sformatf("u%0d_oeb_low_needs_ceb_low_rnw_high", u), (!ob && (cb || !rw)), 1'b0);
      if (!ob) check($sformatf("u%0d_bus_owned_by_sram_when_oeb_low", u), bus, sm);
      check($sformatf("u%0d_rnw_change_while_ceb_low", u),
            ((rw !== prev_rnw[u]) && (!cb || !prev_ceb[u])), 1'b0);
      check($sformatf("u%0d_ack_wider_than_one", u), (ak && prev_ack[u]), 1'b0);
    end
    prev_ceb[u] = cb;
    prev_rnw[u] = rw;
    prev_ack[u] = ak;
    if (ak) ackc[u]++;
  endtask

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [7];
    int          lat;
    logic [7:0]  rd;
    int          base;
    bit          got;
    int          u;
    logic        r;
    logic [15:0] a;
    logic [7:0]  wd;

    vecs[0] = '{0, 1'b0, 16'h1234, 8'hA5, 8'h00, ACC0 + 2};
    vecs[1] = '{0, 1'b1, 16'h1234, 8'h00, 8'hA5, ACC0 + 2};
    vecs[2] = '{1, 1'b0, 16'hFFFF, 8'h3C, 8'h00, ACC1 + 2};
    vecs[3] = '{1, 1'b1, 16'h0000, 8'h00, 8'h5A, ACC1 + 2};
    vecs[4] = '{1, 1'b0, 16'h0000, 8'hC3, 8'h00, ACC1 + 2};
    vecs[5] = '{1, 1'b1, 16'hFFFF, 8'h00, 8'h3C, ACC1 + 2};
    vecs[6] = '{1, 1'b1, 16'h0000, 8'h00, 8'hC3, ACC1 + 2};

    for (int i = 0; i < 65536; i++) begin
      sram0[i]      = init_val(16'(i));
      sram1[i]      = init_val(16'(i));
      ref_mem[0][i] = init_val(16'(i));
      ref_mem[1][i] = init_val(16'(i));
    end
    drive_req(0, 1'b0, 1'b1, 16'h0000, 8'h00);
    drive_req(1, 1'b0, 1'b1, 16'h0000, 8'h00);
    chk_en = 1'b0;
    #2 resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_ceb", ceb0, 1'b1);
    check("rst_oeb", oeb0, 1'b1);
    check("rst_rnw", rnw0, 1'b1);
    check("rst_addr", addr0, 16'h0000);
    check("rst_rdata", rdata0, 8'h00);
    check("rst_ack", ack0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_u1_ceb", ceb1, 1'b1);

    resetb = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      prev_ceb[k] = 1'b1;
      prev_rnw[k] = 1'b1;
      prev_ack[k] = 1'b0;
      ackc[k]     = 0;
    end
    chk_en = 1'b1;

    fork
      forever begin
        @(posedge ceb0);
        if (!rnw0) sram0[addr0] = data0;
      end
      forever begin
        @(posedge ceb1);
        if (!rnw1) sram1[addr1] = data1;
      end
      forever begin
        @(negedge clk);
        proto_check(0, ceb0, oeb0, rnw0, ack0, data0, sram0[addr0]);
        proto_check(1, ceb1, oeb1, rnw1, ack1, data1, sram1[addr1]);
      end
    join_none

    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].u, vecs[i].r, vecs[i].a, vecs[i].wd, lat, rd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].r) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      else ref_mem[vecs[i].u][vecs[i].a] = vecs[i].wd;
    end

    base = ackc[0];
    drive_req(0, 1'b1, 1'b1, 16'h0010, 8'h00);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 16'h0010, 8'h99);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 16'h0010, 8'h99);
    got = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      if (ack0) begin
        got = 1'b1;
        break;
      end
    end
    check("busyreq_ack_seen", got, 1'b1);
    check("busyreq_rdata", rdata0, ref_mem[0][16'h0010]);
    drive_req(0, 1'b0, 1'b0, 16'h0010, 8'h99);
    repeat (10) @(posedge clk);
    #1;
    check("busyreq_ack_count", ackc[0] - base, 1);
    check("busyreq_idle", busy0, 1'b0);
    do_access(0, 1'b1, 16'h0010, 8'h00, lat, rd);
    check("busyreq_no_write", rd, ref_mem[0][16'h0010]);

    drive_req(0, 1'b1, 1'b0, 16'h0200, 8'h5A);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 16'h0200, 8'h5A);
    check("midrst_setup_data", data0, 8'h5A);
    check("midrst_setup_rnw", rnw0, 1'b0);
    @(posedge clk); #1;
    check("midrst_in_access", ceb0, 1'b0);
    chk_en = 1'b0;
    resetb = 1'b0;
    #1;
    check("midrst_ceb", ceb0, 1'b1);
    check("midrst_oeb", oeb0, 1'b1);
    check("midrst_rnw", rnw0, 1'b1);
    check_ne("midrst_data_released", data0, 8'h5A);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_ack", ack0, 1'b0);
    check("midrst_rdata", rdata0, 8'h00);
    #1 resetb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_access(0, 1'b0, 16'h0200, 8'h66, lat, rd);
    check("postrst_write_latency", lat, ACC0 + 2);
    ref_mem[0][16'h0200] = 8'h66;
    do_access(0, 1'b1, 16'h0200, 8'h00, lat, rd);
    check("postrst_read", rd, 8'h66);

    for (int i = 0; i < 1000; i++) begin
      u  = int'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      else a = 16'h0100 + 16'($urandom_range(0, 31));
      do_access(u, r, a, wd, lat, rd);
      check($sformatf("rand%0d_latency", i), lat, ((u == 0) ? ACC0 : ACC1) + 2);
      if (r) check($sformatf("rand%0d_u%0d_rdata_%04h", i, u, a), rd, ref_mem[u][a]);
      else ref_mem[u][a] = wd;
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_access_m.md
# sram_access_m

Synchronous initiator for the asynchronous 64Kx8 SRAM interface (addr, data, ceb, rnw, oeb) used across the testbench and board-level models. A single-word request/acknowledge port on the host side becomes a fully registered, glitch-free SRAM read or write cycle. Every cycle has explicit address setup, a programmable access window, and a write-data hold phase. It sits between CPU/bus glue logic and the external SRAM. Its pins connect directly to the SRAM model for verification.

## Interface
- ACC_CYCLES, 2: number of clocks ceb is held low per access; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- req  in  1  host request; sampled only in IDLE.
- req_rnw  in  1  1 = read, 0 = write; captured with req.
- req_addr  in  16  word address; captured with req.
- req_wdata  in  8  write data; captured with req.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  8  read data; valid from the ack cycle until the next read's ack.
- addr  out  16  SRAM address.
- data  inout  8  SRAM data bus; driven only during write cycles.
- ceb  out  1  SRAM chip enable, active low.
- rnw  out  1  SRAM read/not-write.
- oeb  out  1  SRAM output enable, active low.

## Operation
- Reset values: ceb=1, oeb=1, rnw=1, addr=0, data=Z, rdata=0, ack=0, busy=0, state=IDLE. Reset takes effect immediately, including mid-access; an aborted write leaves the addressed location undefined.
- All SRAM-side outputs and the data output-enable come from flops. There is no combinational path from host inputs to the pins.
- IDLE:
  - If req=1, capture req_rnw, req_addr and req_wdata, then go to SETUP.
  - If req=0, stay in IDLE.
- SETUP (1 clock):
  - addr is driven; ceb=1 and oeb=1.
  - Write: rnw=0 and data is driven with the captured write data.
  - Read: rnw=1 and data=Z.
  - Next state is ACCESS; the access counter loads ACC_CYCLES-1.
- ACCESS (ACC_CYCLES clocks):
  - ceb=0.
  - Read: oeb=0.
  - Write: rnw=0, oeb=1, data still driven.
  - The counter decrements each clock. When the counter is 0, the next state is HOLD.
  - Read: rdata loads from data on that same final edge.
- HOLD (1 clock):
  - ceb=1 and oeb=1; addr is unchanged.
  - Write: rnw stays 0 and data stays driven, giving hold time past the ceb rising edge.
  - Next state is DONE.
- DONE (1 clock):
  - rnw=1 and data=Z; ack=1.
  - Next state is IDLE.
- Invariants:
  - data is never driven while oeb=0.
  - oeb=0 only when ceb=0 and rnw=1.
  - rnw changes only while ceb=1.
- Handling of req outside IDLE:
  - req asserted in any state other than IDLE is ignored, with no queueing.
  - If req is still high on return to IDLE, a new transaction is accepted with the values present at that time.
- addr holds its last value in IDLE. The full 16-bit range 0x0000..0xFFFF is legal, with no wrap logic.

## Timing
- req sampled high at edge E0 gives: SETUP during E0..E1, ACCESS during E1..E1+ACC_CYCLES, HOLD for the next cycle, then DONE.
- ack is high for the cycle beginning at edge E0+ACC_CYCLES+2. This is a latency of ACC_CYCLES+2 clocks; 4 clocks at the default.
- busy rises at E0 and falls at the edge leaving DONE. The minimum repeat period is ACC_CYCLES+4 clocks.
- The read sample point is the last ACCESS edge, which gives ACC_CYCLES×Tclk of oeb/ceb-low time. Choose ACC_CYCLES to cover SRAM access time.
- The write data hold after ceb rises is 1 full clock, which covers the 10 ns input hold of the SRAM model at clock periods ≥10 ns.

## Test plan
- Write then read at the default setting, checked against the SRAM model: write 0xA5 to 0x1234, then read 0x1234 -> rdata=0xA5 in the ack cycle, with ack exactly 4 clocks after req is sampled.
- Boundary addresses with ACC_CYCLES=1: write 0x3C to 0xFFFF and 0xC3 to 0x0000, then read both -> 0x3C and 0xC3 respectively. Latency is 3 clocks, and the 0xFFFF write does not alias into 0x0000.
- Request while busy: assert req with a write of 0x99 to 0x0010 during ACCESS of a prior read, then drop req before IDLE -> no write occurs and a later read of 0x0010 returns its old value; only one ack is seen.
- Reset mid-write: assert resetb=0 during ACCESS -> in the same timestep ceb=1, oeb=1, rnw=1 and data=Z. After reset, busy=0, ack=0 and rdata=0; the next access completes normally.
- Continuous protocol checker across 1000 random reads and writes against a scoreboard, with every read returning the scoreboard value. The checker flags any of:
  - data driven while oeb=0;
  - oeb=0 while ceb=1 or rnw=0;
  - rnw changing while ceb=0;
  - ack wider than 1 clock.
